yarvi_trace_ctrl: RTL and testbench
===================================

Name: yarvi_trace_ctrl

Overview:
- Retirement-trace capture controller sitting between the core's writeback stage and the trace disassembler/printer.
- Watches the retirement stream and arms on request. It triggers on a PC match or immediately, then captures a bounded window of retired instructions into an internal ring FIFO.
- Drains records to the consumer over a valid/ready handshake, so tracing can be gated to a region of interest instead of running every cycle.

Parameters:
XLEN, 32, width of pc and writeback value
DEPTH_LOG2, 4, log2 of FIFO depth (16 entries)

Ports:
clock  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
arm  in  1  single-cycle pulse; leaves IDLE and enters ARMED
trig_any  in  1  when 1, trigger on the first retirement after arming
trig_pc  in  XLEN  trigger address when trig_any=0
capture_len  in  16  records to capture, including the trigger; 0 = unbounded until stop
stop  in  1  pulse; ends ARMED or CAPTURE
ret_valid  in  1  a retirement occurs this cycle
ret_pc  in  XLEN  retired pc
ret_insn  in  32  retired instruction word
ret_rd  in  5  destination register (0 = no write)
ret_val  in  XLEN  writeback value
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_pc  out  XLEN  head pc
out_insn  out  32  head instruction
out_rd  out  5  head rd
out_val  out  XLEN  head writeback value
out_seq  out  16  head sequence number
state  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DRAIN
overflow  out  1  sticky; a record was dropped since the last arm
dropped  out  16  count of dropped records, saturating at 0xFFFF

Behaviour:
- Reset (async, any time): state=IDLE, FIFO empty, out_valid=0, all out_* buses=0, seq=0, overflow=0, dropped=0, remaining=0. A capture or drain in progress is discarded.

FSM:
- IDLE
  - arm -> ARMED.
  - arm clears seq, overflow and dropped. FIFO contents are kept and continue draining.
- ARMED
  - stop -> IDLE (stop takes priority).
  - ret_valid && (trig_any || ret_pc==trig_pc) -> the triggering record is pushed.
  - remaining is loaded with capture_len-1.
  - Next state: DRAIN if capture_len==1, else CAPTURE.
- CAPTURE
  - Each ret_valid pushes one record and decrements remaining (unbounded mode does not decrement).
  - The push that takes remaining from 1 to 0 -> DRAIN.
  - stop -> DRAIN; a retirement in the same cycle as stop is still captured.
- DRAIN
  - No pushes.
  - FIFO empty and no pop this cycle -> IDLE.
  - FIFO already empty on entry -> IDLE the next cycle.
- arm outside IDLE is ignored.

FIFO / handshake:
- Depth 2^DEPTH_LOG2. Pop occurs when out_valid && out_ready, in any state.
- out_* is presented from the head register. out_valid = (count != 0), with no combinational path from ret_* to out_*.
- Push latency: a record pushed into an empty FIFO at edge N gives out_valid=1 after edge N.
- Push is accepted iff count < DEPTH, or a pop happens in the same cycle.
  - Full plus simultaneous pop: both occur and count is unchanged.
  - Empty plus push: no same-cycle bypass.
- Pointers wrap modulo DEPTH. count is DEPTH_LOG2+1 bits.
- out_* must hold stable while out_valid && !out_ready.

Sequencing / overflow:
- seq increments on every capture attempt, accepted or dropped, wrapping at 16 bits. Each record stores the seq value before the increment.
- A dropped push sets overflow and increments dropped (saturating). Dropped records still count against remaining, so the capture window is defined in retirements, not stored records.

Test Plan:
- trig_any=1, capture_len=3, arm, then 5 retirements with pc 0x100,0x104,0x108,0x10C,0x110 and out_ready=1 -> 3 records out with pc 0x100,0x104,0x108 and seq 0,1,2; state goes ARMED->CAPTURE->DRAIN->IDLE; overflow=0.
- trig_any=0, trig_pc=0x200, capture_len=2, retire 0x1F8,0x1FC,0x200,0x204,0x208 -> outputs pc 0x200 and 0x204 only.
- DEPTH=16, capture_len=20, out_ready=0 throughout capture -> FIFO holds seq 0..15; overflow=1, dropped=4; after out_ready=1, exactly 16 records out and final state IDLE.
- FIFO full with ret_valid and out_ready both asserted in the same cycle -> push accepted, count stays 16, dropped unchanged.
- capture_len=0, arm, 7 retirements, then stop coincident with an 8th retirement -> 8 records (seq 0..7); state CAPTURE->DRAIN->IDLE after drain.
- reset asserted mid-CAPTURE with 5 records queued -> out_valid drops to 0 asynchronously; state=IDLE, overflow=0, dropped=0; after release, a new arm starts again at seq 0.

Source files
------------

// File: rtl/yarvi_trace_ctrl_if.sv
// Retirement-trace bus: the retirement stream coming in from writeback and
// the trace record stream going out to the disassembler/printer.
//
// Handshake (out_*): a record transfers on any rising clock edge where
// out_valid && out_ready. While out_valid is high and out_ready is low, the
// producer holds every out_* field stable. out_valid never depends
// combinationally on out_ready. The ret_* side has no back-pressure. A
// retirement is simply present for the cycle in which ret_valid is high.
//
// Modports:
//   master : environment side (drives ret_*, out_ready; observes out_*)
//   slave  : trace controller side (observes ret_*, out_ready; drives out_*)
interface yarvi_trace_ctrl_if #(
  parameter int XLEN = 32
);
  logic            ret_valid;
  logic [XLEN-1:0] ret_pc;
  logic [31:0]     ret_insn;
  logic [4:0]      ret_rd;
  logic [XLEN-1:0] ret_val;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_insn;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_val;
  logic [15:0]     out_seq;

  modport master (
    output ret_valid, ret_pc, ret_insn, ret_rd, ret_val, out_ready,
    input  out_valid, out_pc, out_insn, out_rd, out_val, out_seq
  );

  modport slave (
    input  ret_valid, ret_pc, ret_insn, ret_rd, ret_val, out_ready,
    output out_valid, out_pc, out_insn, out_rd, out_val, out_seq
  );
endinterface

// File: rtl/yarvi_trace_ctrl.sv
// Retirement-trace capture controller. The controller arms on request. It
// triggers on a pc match or on the first retirement. It then captures a
// window of retirements, measured in retirements, into a ring FIFO and
// drains that FIFO to the consumer.
//
// Ports:
//   clock, reset        clock; asynchronous active-high reset
//   arm                 pulse, IDLE -> ARMED (ignored elsewhere)
//   trig_any, trig_pc   trigger on first retirement, or on pc == trig_pc
//   capture_len         window length incl. trigger; 0 = until stop
//   stop                pulse, ends ARMED (-> IDLE) or CAPTURE (-> DRAIN)
//   bus                 retirement input and record output (see interface)
//   state               0 IDLE, 1 ARMED, 2 CAPTURE, 3 DRAIN
//   overflow, dropped   sticky drop flag and saturating drop count
module yarvi_trace_ctrl #(
  parameter int XLEN       = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  trig_any,
  input  logic [XLEN-1:0]       trig_pc,
  input  logic [15:0]           capture_len,
  input  logic                  stop,
  yarvi_trace_ctrl_if.slave     bus,
  output logic [1:0]            state,
  output logic                  overflow,
  output logic [15:0]           dropped
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t                st;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [15:0]           seq;
  logic [15:0]           remaining;
  logic                  unbounded;

  logic [XLEN-1:0]       mem_pc   [DEPTH];
  logic [31:0]           mem_insn [DEPTH];
  logic [4:0]            mem_rd   [DEPTH];
  logic [XLEN-1:0]       mem_val  [DEPTH];
  logic [15:0]           mem_seq  [DEPTH];

  logic trig_hit;
  logic push_req;
  logic push_ok;
  logic pop;
  logic has_data;

  assign trig_hit = bus.ret_valid && (trig_any || (bus.ret_pc == trig_pc));
  assign has_data = (count != '0);
  assign pop      = has_data && bus.out_ready;

  // A capture attempt. In ARMED, stop wins over a trigger in the same
  // cycle. In CAPTURE, a retirement alongside stop is still captured.
  always_comb begin
    push_req = 1'b0;
    case (st)
      S_ARMED:   push_req = trig_hit && !stop;
      S_CAPTURE: push_req = bus.ret_valid;
      default:   push_req = 1'b0;
    endcase
  end

  // When the FIFO is full, a push can still land if the head leaves in the
  // same cycle. The write then reuses the slot being vacated.
  assign push_ok = push_req && ((count != DEPTH_CNT) || pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st        <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      seq       <= '0;
      remaining <= '0;
      unbounded <= 1'b0;
      overflow  <= 1'b0;
      dropped   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (DEPTH_LOG2)'(1);
      if (pop)     rd_ptr <= rd_ptr + (DEPTH_LOG2)'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
        default: count <= count;
      endcase

      case (st)
        S_IDLE: begin
          if (arm) begin
            st       <= S_ARMED;
            seq      <= '0;
            overflow <= 1'b0;
            dropped  <= '0;
          end
        end
        S_ARMED: begin
          if (stop) begin
            st <= S_IDLE;
          end else if (trig_hit) begin
            // The trigger itself is the first record of the window.
            remaining <= capture_len - 16'd1;
            unbounded <= (capture_len == 16'd0);
            st        <= (capture_len == 16'd1) ? S_DRAIN : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (push_req && !unbounded) remaining <= remaining - 16'd1;
          if (stop || (push_req && !unbounded && remaining == 16'd1))
            st <= S_DRAIN;
        end
        S_DRAIN: begin
          if (count == '0) st <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase

      // Every attempt consumes a sequence number, even when the record is
      // dropped. Gaps in out_seq therefore reveal losses to the consumer.
      if (push_req) begin
        seq <= seq + 16'd1;
        if (!push_ok) begin
          overflow <= 1'b1;
          if (dropped != 16'hFFFF) dropped <= dropped + 16'd1;
        end
      end
    end
  end

  // Storage is not reset. Only the occupancy count decides what is visible.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_pc[wr_ptr]   <= bus.ret_pc;
      mem_insn[wr_ptr] <= bus.ret_insn;
      mem_rd[wr_ptr]   <= bus.ret_rd;
      mem_val[wr_ptr]  <= bus.ret_val;
      mem_seq[wr_ptr]  <= seq;
    end
  end

  // The head is read from registered storage at a registered pointer. There
  // is no path from ret_* to out_*. The value is forced to zero when empty,
  // so reset clears the buses immediately.
  assign bus.out_valid = has_data;
  assign bus.out_pc    = has_data ? mem_pc[rd_ptr]   : '0;
  assign bus.out_insn  = has_data ? mem_insn[rd_ptr] : '0;
  assign bus.out_rd    = has_data ? mem_rd[rd_ptr]   : '0;
  assign bus.out_val   = has_data ? mem_val[rd_ptr]  : '0;
  assign bus.out_seq   = has_data ? mem_seq[rd_ptr]  : '0;

  assign state = st;
endmodule

// File: tb/tb_yarvi_trace_ctrl.sv
module tb_yarvi_trace_ctrl;
  localparam int XLEN  = 32;
  localparam int DEPTH = 16;
  localparam int RW    = 16 + XLEN + 5 + 32 + XLEN;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic            arm, trig_any, stop;
  logic [XLEN-1:0] trig_pc;
  logic [15:0]     capture_len;
  logic [1:0]      state;
  logic            overflow;
  logic [15:0]     dropped;

  yarvi_trace_ctrl_if #(.XLEN(XLEN)) bus ();

  yarvi_trace_ctrl #(.XLEN(XLEN), .DEPTH_LOG2(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .arm         (arm),
    .trig_any    (trig_any),
    .trig_pc     (trig_pc),
    .capture_len (capture_len),
    .stop        (stop),
    .bus         (bus),
    .state       (state),
    .overflow    (overflow),
    .dropped     (dropped)
  );

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            n_out = 0;
  logic [XLEN-1:0] last_pc;
  logic [15:0]     last_seq;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge when valid && ready.
  always @(negedge clock) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL record: got seq %0d pc %h with nothing expected", bus.out_seq, bus.out_pc);
      end else begin
        logic [RW-1:0] e;
        e = exp_q.pop_front();
        check("record", {bus.out_seq, bus.out_val, bus.out_rd, bus.out_insn, bus.out_pc}, e);
      end
      last_pc  = bus.out_pc;
      last_seq = bus.out_seq;
      n_out++;
    end
  end

  // ---------------- reference model ----------------
  // The model is phrased as "what the trace unit is doing" (0 idle,
  // 1 waiting for trigger, 2 recording, 3 emptying). It also tracks how many
  // retirements are left in the window (-1 means no limit) and how many
  // records sit in a 16-slot buffer.
  int          m_mode, m_count, m_left;
  logic [15:0] m_seq, m_dropped;
  logic        m_ovf;

  task automatic model_reset();
    exp_q.delete();
    m_mode = 0; m_count = 0; m_left = 0;
    m_seq = '0; m_dropped = '0; m_ovf = 1'b0;
  endtask

  task automatic model_step();
    bit pop_m, attempt, acc;
    pop_m   = (m_count > 0) && bus.out_ready;
    attempt = 0;
    acc     = 0;
    if (m_mode == 0) begin
      if (arm) begin m_mode = 1; m_seq = '0; m_ovf = 1'b0; m_dropped = '0; end
    end else if (m_mode == 1) begin
      if (stop) m_mode = 0;
      else if (bus.ret_valid && (trig_any || bus.ret_pc == trig_pc)) begin
        attempt = 1;
        m_left  = (capture_len == 0) ? -1 : int'(capture_len);
        m_mode  = 2;
      end
    end else if (m_mode == 2) begin
      attempt = bus.ret_valid;
      if (stop) m_mode = 3;
    end else if (m_count == 0) begin
      m_mode = 0;
    end
    if (attempt) begin
      acc = (m_count < DEPTH) || pop_m;
      if (acc) exp_q.push_back({m_seq, bus.ret_val, bus.ret_rd, bus.ret_insn, bus.ret_pc});
      else begin
        m_ovf = 1'b1;
        if (m_dropped != 16'hFFFF) m_dropped = m_dropped + 16'd1;
      end
      m_seq = m_seq + 16'd1;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_mode = 3;
      end
    end
    m_count = m_count + int'(acc) - int'(pop_m);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clock);
    check("out_valid", bus.out_valid, m_count != 0);
    check("state", state, m_mode);
    check("overflow", overflow, m_ovf);
    check("dropped", dropped, m_dropped);
    model_step();
    @(posedge clock);
    #1;
    arm  = 1'b0;
    stop = 1'b0;
  endtask

  task automatic retire(input logic [XLEN-1:0] pc);
    bus.ret_valid = 1'b1;
    bus.ret_pc    = pc;
    bus.ret_insn  = $urandom;
    bus.ret_rd    = 5'($urandom_range(0, 31));
    bus.ret_val   = $urandom;
    tick();
    bus.ret_valid = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 120; i++) begin
      if (state == 2'd0 && m_count == 0 && exp_q.size() == 0) break;
      tick();
    end
    check("drain_idle", state, 2'd0);
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic setup(input logic any, input logic [XLEN-1:0] tpc, input logic [15:0] len, input logic rdy);
    trig_any = any; trig_pc = tpc; capture_len = len; bus.out_ready = rdy;
    arm = 1'b1;
    tick();
  endtask

  // ---------------- stimulus ----------------
  int n0;
  initial begin
    arm = 0; stop = 0; trig_any = 0; trig_pc = '0; capture_len = '0;
    bus.ret_valid = 0; bus.ret_pc = '0; bus.ret_insn = '0; bus.ret_rd = '0;
    bus.ret_val = '0; bus.out_ready = 0;
    model_reset();
    #12;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_bus", {bus.out_seq, bus.out_val, bus.out_rd, bus.out_insn, bus.out_pc}, '0);
    check("rst_state", state, 2'd0);
    check("rst_ovf_drop", {overflow, dropped}, '0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Immediate trigger, window of 3.
    n0 = n_out;
    setup(1'b1, '0, 16'd3, 1'b1);
    for (int i = 0; i < 5; i++) retire(32'h100 + 32'(4 * i));
    drain();
    check("t1_count", n_out - n0, 3);
    check("t1_last", {last_seq, last_pc}, {16'd2, 32'h108});
    check("t1_ovf", overflow, 1'b0);

    // PC trigger, window of 2.
    n0 = n_out;
    setup(1'b0, 32'h200, 16'd2, 1'b1);
    for (int i = 0; i < 5; i++) retire(32'h1F8 + 32'(4 * i));
    drain();
    check("t2_count", n_out - n0, 2);
    check("t2_last", {last_seq, last_pc}, {16'd1, 32'h204});

    // Window of 20 into a 16-deep FIFO with no consumer.
    n0 = n_out;
    setup(1'b1, '0, 16'd20, 1'b0);
    for (int i = 0; i < 20; i++) retire(32'h1000 + 32'(4 * i));
    check("t3_ovf", overflow, 1'b1);
    check("t3_dropped", dropped, 16'd4);
    check("t3_state", state, 2'd3);
    drain();
    check("t3_count", n_out - n0, 16);
    check("t3_last", {last_seq, last_pc}, {16'd15, 32'h103C});

    // Full FIFO with push and pop together, then a push that must drop.
    n0 = n_out;
    setup(1'b1, '0, 16'd0, 1'b0);
    for (int i = 0; i < 16; i++) retire(32'h2000 + 32'(4 * i));
    bus.out_ready = 1'b1;
    retire(32'h3000);
    bus.out_ready = 1'b0;
    check("t4_dropped_same", dropped, 16'd0);
    retire(32'h3004);
    check("t4_dropped_full", dropped, 16'd1);
    stop = 1'b1;
    tick();
    drain();
    check("t4_count", n_out - n0, 17);
    check("t4_last", {last_seq, last_pc}, {16'd16, 32'h3000});

    // Unbounded, with stop coincident with the 8th retirement.
    n0 = n_out;
    setup(1'b1, '0, 16'd0, 1'b1);
    for (int i = 0; i < 7; i++) retire(32'h400 + 32'(4 * i));
    check("t5_state_cap", state, 2'd2);
    stop = 1'b1;
    retire(32'h41C);
    check("t5_state_drain", state, 2'd3);
    drain();
    check("t5_count", n_out - n0, 8);
    check("t5_last", {last_seq, last_pc}, {16'd7, 32'h41C});

    // Asynchronous reset mid-capture.
    setup(1'b1, '0, 16'd0, 1'b0);
    for (int i = 0; i < 5; i++) retire(32'h500 + 32'(4 * i));
    check("t6_pre_valid", bus.out_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_valid", bus.out_valid, 1'b0);
    check("t6_rst_state", state, 2'd0);
    check("t6_rst_ovf_drop", {overflow, dropped}, '0);
    model_reset();
    reset = 1'b0;
    n0 = n_out;
    setup(1'b1, '0, 16'd1, 1'b1);
    retire(32'h600);
    drain();
    check("t6_count", n_out - n0, 1);
    check("t6_seq", {last_seq, last_pc}, {16'd0, 32'h600});

    // Randomized sessions.
    for (int s = 0; s < 8; s++) begin
      setup(1'($urandom_range(0, 1)), 32'h40 + 32'(4 * $urandom_range(0, 7)),
            16'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
      for (int c = 0; c < 40; c++) begin
        bus.out_ready = ($urandom_range(0, 2) != 0);
        arm  = ($urandom_range(0, 15) == 0);
        stop = ($urandom_range(0, 31) == 0);
        if ($urandom_range(0, 2) != 0) retire(32'h40 + 32'(4 * $urandom_range(0, 7)));
        else tick();
      end
      stop = 1'b1;
      tick();
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
